// File: rtl/rom_read_ctrl.sv
// rom_read_ctrl -- synchronous read sequencer for an asynchronous 8K ROM.
//
// A byte read is accepted from the bus side over a valid/ready handshake.
// The block then drives the ROM address and the active-low chip-select and
// output-enable lines through a fixed sequence:
//   SETUP   : address and CS are valid and OE is high, for one cycle
//   ACCESS  : OE is low for WAIT_CYCLES cycles, and the data bus is sampled
//             on the last edge
//   RESP    : the sampled byte is held on resp_* until it is consumed
//   RECOVER : one cycle with CS and OE high, so that consecutive CS pulses
//             are separated on the bus
// Every output is registered. Reset is synchronous and active-low.
//
// Optional build macro ROM_READ_CTRL_PREFETCH_EN:
//   When the block goes idle after a read at address A and no request is
//   waiting, it reads A+1 speculatively and keeps the byte in a prefetch
//   buffer. A later request that hits that address skips the ROM cycle.
//   A hit responds one edge after the accept.
//
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   req_valid/ready/addr   read request channel (address is held by the
//                          requester until it is accepted)
//   resp_valid/ready/data  read response channel
//   rom_addr, rom_cs_n,    ROM control outputs
//   rom_oe_n
//   rom_data               ROM data bus, input only
//   busy                   high in every state except IDLE
module rom_read_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs_n,
  output logic              rom_oe_n,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  // A window shorter than one cycle would sample before OE takes effect.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = $clog2(WAIT_EFF + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_EFF);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    RESP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                rv_q, rv_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                rdy_q, rdy_d;
  logic                busy_q;

  logic                accept;
  // pf_start : begin a speculative read this edge
  // pf_hit_q : the SETUP cycle serves a buffered byte and no ROM cycle runs
  // pf_run_q : the ROM cycle in flight is speculative
  logic                pf_start;
  logic                pf_hit_q;
  logic                pf_run_q;

  assign accept = (state_q == IDLE) && req_valid && rdy_q;

`ifdef ROM_READ_CTRL_PREFETCH_EN
  logic                pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0]   pf_addr_q, pf_addr_d;
  logic [DATA_W-1:0]   pf_data_q, pf_data_d;
  logic                pf_armed_q, pf_armed_d;
  logic                pf_run_d, pf_hit_d;
  logic                hit_now;

  // pf_addr_q holds the next speculative target while the buffer is armed,
  // and the address of the buffered byte once pf_valid_q is set.
  assign hit_now  = accept && pf_valid_q && (req_addr == pf_addr_q);
  assign pf_start = (state_q == IDLE) && !req_valid && pf_armed_q;
`else
  assign pf_start = 1'b0;
  assign pf_hit_q = 1'b0;
  assign pf_run_q = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept || pf_start) state_d = SETUP;
      SETUP:   state_d = pf_hit_q ? RESP : ACCESS;
      ACCESS:  if (cnt_q == CNT_ONE) state_d = pf_run_q ? RECOVER : RESP;
      RESP:    if (resp_ready) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next values of the registered outputs and the datapath
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    cs_n_d = cs_n_q;
    oe_n_d = oe_n_q;
    rv_d   = rv_q;
    rd_d   = rd_q;
    rdy_d  = 1'b0;
`ifdef ROM_READ_CTRL_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_armed_d = pf_armed_q;
    pf_run_d   = pf_run_q;
    pf_hit_d   = pf_hit_q;
`endif
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d = 1'b0;
`ifdef ROM_READ_CTRL_PREFETCH_EN
          // A hit or a miss consumes the buffer. Either way, the next
          // sequential address becomes the speculative target.
          pf_valid_d = 1'b0;
          pf_armed_d = 1'b1;
          if (hit_now) begin
            pf_hit_d  = 1'b1;
            pf_addr_d = pf_addr_q + ADDR_ONE;
          end else begin
            addr_d    = req_addr;
            cs_n_d    = 1'b0;
            pf_addr_d = req_addr + ADDR_ONE;
          end
`else
          addr_d = req_addr;
          cs_n_d = 1'b0;
`endif
        end else if (pf_start) begin
          rdy_d = 1'b0;
`ifdef ROM_READ_CTRL_PREFETCH_EN
          addr_d     = pf_addr_q;
          cs_n_d     = 1'b0;
          pf_armed_d = 1'b0;
          pf_run_d   = 1'b1;
`endif
        end
      end
      SETUP: begin
        if (pf_hit_q) begin
`ifdef ROM_READ_CTRL_PREFETCH_EN
          pf_hit_d = 1'b0;
          rv_d     = 1'b1;
          rd_d     = pf_data_q;
`endif
        end else begin
          oe_n_d = 1'b0;
          cnt_d  = CNT_LOAD;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_ONE;
        // rom_data is captured only on this edge, so X/Z seen on the bus
        // at any other time never reaches resp_data.
        if (cnt_q == CNT_ONE) begin
          cs_n_d = 1'b1;
          oe_n_d = 1'b1;
          if (pf_run_q) begin
`ifdef ROM_READ_CTRL_PREFETCH_EN
            pf_data_d  = rom_data;
            pf_valid_d = 1'b1;
            pf_run_d   = 1'b0;
`endif
          end else begin
            rd_d = rom_data;
            rv_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (resp_ready) rv_d = 1'b0;
      end
      RECOVER: begin
        rdy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef ROM_READ_CTRL_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_armed_q <= 1'b0;
      pf_run_q   <= 1'b0;
      pf_hit_q   <= 1'b0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_armed_q <= pf_armed_d;
      pf_run_q   <= pf_run_d;
      pf_hit_q   <= pf_hit_d;
    end
  end
`endif

  // The ready register comes up cleared one edge after reset. The AND with
  // reset_n keeps req_ready low while reset is asserted, before that edge.
  assign req_ready  = rdy_q & reset_n;
  assign resp_valid = rv_q;
  assign resp_data  = rd_q;
  assign rom_addr   = addr_q;
  assign rom_cs_n   = cs_n_q;
  assign rom_oe_n   = oe_n_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rom_read_ctrl.sv
// Testbench for rom_read_ctrl. The ROM is modelled as a random array that
// drives the data bus only while CS and OE are both low, and Z otherwise.
// A bus monitor records every CS pulse. Each test task compares the DUT
// against a reference model of the expected latency and data.
module tb_rom_read_ctrl;

  localparam int W       = 4;
  localparam int PF_IDLE = W + 6;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [12:0] rom_addr;
  logic        rom_cs_n;
  logic        rom_oe_n;
  wire  [7:0]  rom_data;
  logic        busy;

  logic [7:0]  rom_mem [0:8191];

  int checks = 0;
  int errors = 0;

  rom_read_ctrl #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .rom_addr   (rom_addr),
    .rom_cs_n   (rom_cs_n),
    .rom_oe_n   (rom_oe_n),
    .rom_data   (rom_data),
    .busy       (busy)
  );

  assign rom_data = (rom_cs_n === 1'b0 && rom_oe_n === 1'b0) ? rom_mem[rom_addr] : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus monitor: one record per CS pulse ----------------
  typedef struct {
    logic [12:0] addr;
    int          setup;
    int          oe;
    bit          addr_bad;
    bit          aborted;
    int          gap;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  bit     in_pulse = 1'b0;
  int     hi_run   = 1000;
  int     oe_stray = 0;

  always @(negedge clk) begin
    if (rom_oe_n === 1'b0 && rom_cs_n !== 1'b0) oe_stray <= oe_stray + 1;
    if (rom_cs_n === 1'b0) begin
      hi_run <= 0;
      if (!in_pulse) begin
        in_pulse     <= 1'b1;
        cur.addr     <= rom_addr;
        cur.setup    <= (rom_oe_n === 1'b1) ? 1 : 0;
        cur.oe       <= (rom_oe_n === 1'b0) ? 1 : 0;
        cur.addr_bad <= 1'b0;
        cur.aborted  <= !reset_n;
        cur.gap      <= hi_run;
      end else begin
        if (rom_addr !== cur.addr) cur.addr_bad <= 1'b1;
        if (rom_oe_n === 1'b1 && cur.oe == 0) cur.setup <= cur.setup + 1;
        if (rom_oe_n === 1'b0) cur.oe <= cur.oe + 1;
        if (!reset_n) cur.aborted <= 1'b1;
      end
    end else begin
      hi_run <= hi_run + 1;
      if (in_pulse) begin
        in_pulse <= 1'b0;
        pulses.push_back(cur);
      end
    end
  end

  // ---------------- reference model ----------------
`ifdef ROM_READ_CTRL_PREFETCH_EN
  bit          m_armed = 1'b0;
  bit          m_pfv   = 1'b0;
  logic [12:0] m_next  = '0;
  logic [12:0] m_pfa   = '0;
`endif

  // Returns the expected number of edges from the accept to resp_valid.
  // Call it for every completed read, with the idle cycles spent before
  // the request was raised.
  function automatic int model_read(input logic [12:0] addr, input int gap);
    bit hit;
    hit = 1'b0;
`ifdef ROM_READ_CTRL_PREFETCH_EN
    if (m_armed && gap >= PF_IDLE) begin
      m_pfv   = 1'b1;
      m_pfa   = m_next;
      m_armed = 1'b0;
    end
    hit     = m_pfv && (addr == m_pfa);
    m_pfv   = 1'b0;
    m_armed = 1'b1;
    m_next  = addr + 13'd1;
`else
    if (addr === 13'hx && gap < 0) hit = 1'b0;
`endif
    return hit ? 1 : W + 1;
  endfunction

  function automatic void model_reset();
`ifdef ROM_READ_CTRL_PREFETCH_EN
    m_armed = 1'b0;
    m_pfv   = 1'b0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle for 'gap' cycles, then raise the request and wait for the accept.
  // Returns the number of edges from the accept to resp_valid (-1 on
  // timeout) and the byte sampled then. This task does not complete the
  // response handshake.
  task automatic do_read(input logic [12:0] addr, input int gap,
                         output int lat, output logic [7:0] data);
    int n;
    repeat (gap) step();
    req_valid = 1'b1;
    req_addr  = addr;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    step();
    req_valid = 1'b0;
    req_addr  = 13'($urandom);
    lat  = -1;
    data = 8'hxx;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (resp_valid === 1'b1) begin
        lat  = i;
        data = resp_data;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b want 0", req_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (rom_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", rom_cs_n); end
      checks++; if (rom_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", rom_oe_n); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rom_addr !== 13'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
      checks++; if (resp_data !== 8'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    end
    reset_n = 1'b1;
    model_reset();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b want 0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    checks++; if (rom_cs_n !== 1'b1) begin errors++; $display("FAIL reset_no_accept: cs_n got %b want 1", rom_cs_n); end
    req_valid = 1'b0;
  endtask

  task automatic test_single_read();
    int lat, exp;
    logic [7:0] d;
    resp_ready = 1'b1;
    exp = model_read(13'h0123, 2);
    do_read(13'h0123, 2, lat, d);
    checks++; if (lat !== exp) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, exp); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", d); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_handshake: resp_valid got %b want 0", resp_valid); end
    checks++;
    if (pulses.size() == 0) begin errors++; $display("FAIL single_pulse: got 0 pulses want 1"); end
    else begin
      if (pulses[$].addr !== 13'h0123 || pulses[$].setup != 1 || pulses[$].oe != W) begin
        errors++;
        $display("FAIL single_pulse: got addr %h setup %0d oe %0d want 0123 1 %0d",
                 pulses[$].addr, pulses[$].setup, pulses[$].oe, W);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, exp;
    logic [7:0] d;
    resp_ready = 1'b0;
    exp = model_read(13'h0123, PF_IDLE);
    do_read(13'h0123, PF_IDLE, lat, d);
    checks++; if (lat !== exp) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, exp); end
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL bp_data: got %h want a5", d); end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, resp_valid); end
      checks++; if (resp_data !== 8'hA5) begin errors++; $display("FAIL bp_hold_data: cycle %0d got %h want a5", c, resp_data); end
      checks++; if (rom_cs_n !== 1'b1) begin errors++; $display("FAIL bp_cs_n: cycle %0d got %b want 1", c, rom_cs_n); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: cycle %0d got %b want 0", c, req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: cycle %0d got %b want 1", c, busy); end
    end
    resp_ready = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_recover_ready: got %b want 0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int l1, l2, e1, e2;
    logic [7:0] d1, d2;
    resp_ready = 1'b1;
    e1 = model_read(13'h1FFF, 0);
    do_read(13'h1FFF, 0, l1, d1);
    step();
    e2 = model_read(13'h0000, 0);
    do_read(13'h0000, 0, l2, d2);
    step();
    checks++; if (l1 !== e1) begin errors++; $display("FAIL b2b_lat1: got %0d want %0d", l1, e1); end
    checks++; if (d1 !== 8'h3C) begin errors++; $display("FAIL b2b_data1: got %h want 3c", d1); end
    checks++; if (l2 !== e2) begin errors++; $display("FAIL b2b_lat2: got %0d want %0d", l2, e2); end
    checks++; if (d2 !== 8'hC3) begin errors++; $display("FAIL b2b_data2: got %h want c3", d2); end
    checks++;
    if (pulses.size() < 2) begin errors++; $display("FAIL b2b_pulses: got %0d want >=2", pulses.size()); end
    else if (pulses[$-1].addr !== 13'h1FFF || pulses[$].addr !== 13'h0000 || pulses[$].gap < 1) begin
      errors++;
      $display("FAIL b2b_pulses: got %h,%h gap %0d want 1fff,0000 gap>=1",
               pulses[$-1].addr, pulses[$].addr, pulses[$].gap);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, exp, n;
    bit seen;
    logic [7:0] d;
    req_valid = 1'b1;
    req_addr  = 13'h0040;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin step(); n++; end
    step();
    req_valid = 1'b0;
    repeat (3) step();
    checks++; if (rom_oe_n !== 1'b0) begin errors++; $display("FAIL mid_in_access: oe_n got %b want 0", rom_oe_n); end
    reset_n = 1'b0;
    step();
    checks++; if (rom_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %b want 1", rom_cs_n); end
    checks++; if (rom_oe_n !== 1'b1) begin errors++; $display("FAIL mid_oe_n: got %b want 1", rom_oe_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready: got %b want 0", req_ready); end
    reset_n = 1'b1;
    model_reset();
    seen = (resp_valid !== 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_resp: got resp_valid pulse want none"); end
    exp = model_read(13'h0005, 0);
    do_read(13'h0005, 0, lat, d);
    checks++; if (lat !== exp) begin errors++; $display("FAIL mid_after_lat: got %0d want %0d", lat, exp); end
    checks++; if (d !== rom_mem[5]) begin errors++; $display("FAIL mid_after_data: got %h want %h", d, rom_mem[5]); end
    step();
  endtask

  task automatic test_random_reads();
    int lat, exp, gap, dly;
    logic [12:0] addr, prev;
    logic [7:0] d;
    prev = 13'h0005;
    for (int i = 0; i < 24; i++) begin
      addr = ($urandom_range(0, 2) == 0) ? prev + 13'd1 : 13'($urandom);
      gap  = ($urandom_range(0, 1) == 0) ? 0 : PF_IDLE + int'($urandom_range(0, 3));
      dly  = int'($urandom_range(0, 3));
      resp_ready = (dly == 0);
      exp = model_read(addr, gap);
      do_read(addr, gap, lat, d);
      checks++; if (lat !== exp) begin errors++; $display("FAIL rand_lat[%0d]: addr %h got %0d want %0d", i, addr, lat, exp); end
      checks++; if (d !== rom_mem[addr]) begin errors++; $display("FAIL rand_data[%0d]: addr %h got %h want %h", i, addr, d, rom_mem[addr]); end
      repeat (dly) step();
      resp_ready = 1'b1;
      step();
      prev = addr;
    end
  endtask

`ifdef ROM_READ_CTRL_PREFETCH_EN
  task automatic test_prefetch_hit();
    int lat, exp, n0;
    logic [7:0] d;
    resp_ready = 1'b1;
    exp = model_read(13'h0010, 0);
    do_read(13'h0010, 0, lat, d);
    step();
    n0 = pulses.size();
    exp = model_read(13'h0011, PF_IDLE);
    do_read(13'h0011, PF_IDLE, lat, d);
    checks++; if (lat !== exp || exp != 1) begin errors++; $display("FAIL pf_hit_lat: got %0d want 1", lat); end
    checks++; if (d !== rom_mem[13'h0011]) begin errors++; $display("FAIL pf_hit_data: got %h want %h", d, rom_mem[13'h0011]); end
    checks++;
    if (pulses.size() != n0 + 1 || pulses[$].addr !== 13'h0011) begin
      errors++; $display("FAIL pf_hit_pulses: got %0d new pulses want 1 speculative to 0011", pulses.size() - n0);
    end
    step();
    n0 = pulses.size();
    exp = model_read(13'h0012, PF_IDLE);
    do_read(13'h0012, PF_IDLE, lat, d);
    checks++; if (lat !== exp || exp != 1) begin errors++; $display("FAIL pf_chain_lat: got %0d want 1", lat); end
    checks++; if (d !== rom_mem[13'h0012]) begin errors++; $display("FAIL pf_chain_data: got %h want %h", d, rom_mem[13'h0012]); end
    checks++;
    if (pulses.size() != n0 + 1 || pulses[$].addr !== 13'h0012) begin
      errors++; $display("FAIL pf_chain_pulses: got %0d new pulses want 1 speculative to 0012", pulses.size() - n0);
    end
    step();
  endtask

  task automatic test_prefetch_wrap();
    int lat, exp, n0;
    logic [7:0] d;
    resp_ready = 1'b1;
    exp = model_read(13'h1FFF, 0);
    do_read(13'h1FFF, 0, lat, d);
    step();
    n0 = pulses.size();
    repeat (PF_IDLE) step();
    checks++;
    if (pulses.size() != n0 + 1 || pulses[$].addr !== 13'h0000) begin
      errors++; $display("FAIL pf_wrap_pulse: got %0d new pulses want 1 speculative to 0000", pulses.size() - n0);
    end
    exp = model_read(13'h0000, PF_IDLE);
    do_read(13'h0000, 0, lat, d);
    checks++; if (lat !== exp || exp != 1) begin errors++; $display("FAIL pf_wrap_lat: got %0d want 1", lat); end
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL pf_wrap_data: got %h want c3", d); end
    step();
  endtask
`endif

  task automatic test_bus_protocol();
    int aborted;
    aborted = 0;
    foreach (pulses[i]) begin
      if (pulses[i].aborted) aborted++;
      else begin
        checks++;
        if (pulses[i].setup != 1 || pulses[i].oe != W) begin
          errors++; $display("FAIL bus_timing[%0d]: got setup %0d oe %0d want 1 %0d", i, pulses[i].setup, pulses[i].oe, W);
        end
      end
      checks++; if (pulses[i].addr_bad) begin errors++; $display("FAIL bus_addr_stable[%0d]: got change want none", i); end
      checks++; if (pulses[i].gap < 1) begin errors++; $display("FAIL bus_gap[%0d]: got %0d want >=1", i, pulses[i].gap); end
    end
    checks++; if (aborted != 1) begin errors++; $display("FAIL bus_aborted: got %0d want 1", aborted); end
    checks++; if (oe_stray != 0) begin errors++; $display("FAIL bus_oe_stray: got %0d want 0", oe_stray); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 8'($urandom);
    rom_mem[13'h0123] = 8'hA5;
    rom_mem[13'h1FFF] = 8'h3C;
    rom_mem[13'h0000] = 8'hC3;
    reset_n    = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 13'h0123;
    resp_ready = 1'b1;
    #1;
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    test_random_reads();
`ifdef ROM_READ_CTRL_PREFETCH_EN
    test_prefetch_hit();
    test_prefetch_wrap();
`endif
    repeat (2) step();
    test_bus_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_read_ctrl.md
Name: rom_read_ctrl

Overview:
- Synchronous read sequencer that sits directly upstream of the asynchronous 8K ROM.
- Accepts byte-read requests from the CPU/bus side over a valid/ready handshake.
- Drives the ROM's address, active-low chip-select and active-low output-enable with a programmable access window, then samples the ROM data bus.
- Returns the sampled byte over a valid/ready response channel.

Parameters:
- ADDR_W, 13, ROM address width (8K).
- DATA_W, 8, ROM data width.
- WAIT_CYCLES, 4, clocks the ROM output-enable is held low before sampling; covers the ROM's 150 ns output delay. Values below 1 are treated as 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  1  read request present.
- req_ready  output  1  controller can accept a request.
- req_addr  input  ADDR_W  byte address to read.
- resp_valid  output  1  resp_data is valid.
- resp_ready  input  1  consumer takes the response.
- resp_data  output  DATA_W  byte read from the ROM.
- rom_addr  output  ADDR_W  ROM address bus.
- rom_cs_n  output  1  ROM chip select, active low.
- rom_oe_n  output  1  ROM output enable, active low.
- rom_data  input  DATA_W  ROM data bus; this block never drives it.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
- Reset values: state IDLE, rom_cs_n=1, rom_oe_n=1, rom_addr=0, resp_valid=0, resp_data=0, busy=0, counter=0.
  - req_ready=0 while reset_n=0.
- FSM states: IDLE, SETUP, ACCESS, RESP, RECOVER. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On edge with req_valid && req_ready: rom_addr<=req_addr, rom_cs_n<=0, go to SETUP.
- SETUP (1 cycle):
  - rom_cs_n=0, rom_oe_n=1 (address/CS setup before OE).
  - Next edge: rom_oe_n<=0, counter<=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - Counter decrements each edge.
  - On the edge where counter==1: resp_data<=rom_data, resp_valid<=1, rom_cs_n<=1, rom_oe_n<=1, go to RESP.
  - rom_oe_n is low for exactly WAIT_CYCLES cycles.
- Latency: accept on edge k gives resp_valid=1 after edge k+WAIT_CYCLES+1.
- RESP:
  - resp_valid and resp_data are held stable until resp_ready=1 at an edge.
  - rom_addr is held. req_ready=0.
  - On handshake: resp_valid<=0, go to RECOVER.
- RECOVER (1 cycle):
  - CS and OE stay deasserted, giving a bus turnaround gap of at least 1 cycle between consecutive CS pulses. Then go to IDLE.
- req_ready is 1 only in IDLE. There is no request queueing; the requester must hold req_valid/req_addr until accepted.
- rom_addr is never changed while rom_cs_n=0.
- Reset mid-operation (any state): the next edge applies the reset values. An in-flight read is discarded and no resp_valid pulse is produced.
- A request and reset in the same cycle: reset wins and the request is not accepted.
- rom_data X/Z outside the ACCESS sample edge must not propagate into resp_data.

Optional Feature:
- Macro: ROM_READ_CTRL_PREFETCH_EN.
- With the macro defined:
  - After RECOVER following a read at A, if req_valid=0 in IDLE, the controller starts a speculative read of A+1 (wrapping from 2^ADDR_W-1 to 0) using the same SETUP/ACCESS timing.
  - Prefetch state: pf_valid, pf_addr, pf_data.
  - req_ready=0 while a prefetch is in flight.
  - A later request with pf_valid && req_addr==pf_addr goes straight to RESP: resp_valid after the edge k+1, no CS pulse. It then clears pf_valid and chains the next prefetch.
  - A miss clears pf_valid and performs a normal read.
  - Reset clears pf_valid.
- Without the macro: no speculative cycles, no prefetch registers; IDLE waits indefinitely.

Test Plan:
- Reset: reset_n=0 for 3 cycles with req_valid=1 -> rom_cs_n=rom_oe_n=1, req_ready=0, resp_valid=0; one edge after release req_ready=1.
- Single read, WAIT_CYCLES=4, ROM[0x0123]=0xA5 -> CS low 1 cycle before OE, OE low exactly 4 cycles, resp_valid after accept+5 edges, resp_data=0xA5.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_data stays 0xA5, rom_cs_n=1, req_ready=0 throughout; handshake on cycle 11, then 1 RECOVER cycle before req_ready=1.
- Back-to-back reads of 0x1FFF (0x3C) then 0x0000 (0xC3), resp_ready tied high -> two responses in order with correct data, at least 1 cycle with rom_cs_n=1 between CS pulses.
- Reset pulse during ACCESS (counter=2) -> next edge CS/OE=1, resp_valid never asserts; a subsequent read of 0x0005 completes normally.
- With ROM_READ_CTRL_PREFETCH_EN:
  - Read 0x0010, idle 10 cycles, then read 0x0011 -> resp_valid one edge after accept with no CS pulse.
  - Read 0x1FFF then idle -> speculative CS cycle to rom_addr=0x0000.
